// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store unit, initiator side of a word-addressed data
//               memory port. Byte/halfword stores use read-modify-write;
//               loads are lane-selected and sign/zero-extended. Misaligned,
//               out-of-range and illegal-size requests are answered with an
//               error response without any memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_mem_limit = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Request legality: illegal size, misalignment for its size, or beyond memory
    assign w_req_err = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || (req_addr >= c_mem_limit);

    // Load lane selection and extension from the live memory read data
    always_comb begin
        w_byte     = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_ext = mem_rdata;
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'd0, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = r_unsigned ? {16'd0, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Replace the addressed byte/halfword lane of the previously read word
    always_comb begin
        w_merged = r_merge;
        if (r_size == 2'b00) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // State register and captured request / data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_merge    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_lane     <= req_addr[1:0];
                r_addr     <= {req_addr[31:2], 2'b00};
                r_wdata    <= req_wdata;
                r_rdata    <= 32'd0;
                r_err      <= w_req_err;
            end
            if (r_state == S_LOAD) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_merge <= mem_rdata;
            end
        end
    end

    // Next-state and memory/response strobes decoded from the current state
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = S_DONE;
                    end else if (!req_we) begin
                        w_next = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        w_next = S_STORE;
                    end else begin
                        w_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_read = 1'b1;
                w_next   = S_DONE;
            end
            S_STORE: begin
                mem_write = 1'b1;
                mem_wdata = r_wdata;
                w_next    = S_DONE;
            end
            S_RMW_RD: begin
                mem_read = 1'b1;
                w_next   = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = w_merged;
                w_next    = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign mem_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Scoreboard bench for lsu_mem_master with a byte-array
//               reference model, directed and random requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    localparam int MEM_BYTES = 8192;
    localparam int WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, write on the rising edge
    logic [31:0] tb_mem [WORDS] = '{default: 32'd0};
    assign mem_rdata = tb_mem[mem_addr[12:2]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[12:2]] <= mem_wdata;
    end

    int cyc = 0;
    int wr_total = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) wr_total <= wr_total + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: byte-addressed memory image
    logic [7:0] ref_b [MEM_BYTES] = '{default: 8'd0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    logic mon_off = 1'b0;

    function automatic logic [31:0] ref_word(input int a);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output exp_t e);
        int nb;
        int a;
        logic [31:0] v;
        nb = 1 << size;
        e.rdata = 32'd0;
        e.lat   = -1;
        e.nrd   = 0;
        e.nwr   = 0;
        e.waddr = addr & ~32'd3;
        e.wword = 32'd0;
        e.acc   = 0;
        e.err   = (size == 2'd3) || (addr % nb != 0) || (addr >= MEM_BYTES);
        if (!e.err) begin
            a = int'(addr);
            if (!we) begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_b[a+i]) << (8*i));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                e.rdata = v;
                e.lat   = 2;
                e.nrd   = 1;
            end else begin
                for (int i = 0; i < nb; i++) ref_b[a+i] = wdata[8*i +: 8];
                e.wword = ref_word(a & ~3);
                e.nwr   = 1;
                e.nrd   = (nb == 4) ? 0 : 1;
                e.lat   = (nb == 4) ? 2 : 3;
            end
        end
    endtask

    // Issue one request; optionally keep req_valid high with garbage while busy
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic hold);
        exp_t e;
        int t;
        model(we, size, uns, addr, wdata, e);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (hold) begin
            t = 0;
            forever begin
                @(negedge clk);
                if (resp_valid || t > 10) break;
                check("ready_while_busy", {31'd0, req_ready}, 32'd0);
                req_we = 1'($urandom); req_size = 2'($urandom);
                req_unsigned = 1'($urandom); req_addr = $urandom_range(0, 8191);
                req_wdata = $urandom;
                t++;
            end
        end
        req_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #2;
        if (exp_q.size() > 0) begin
            check("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Monitor: per-access address/data checks and per-response scoreboard pops
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst || mon_off) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read || mem_write) begin
                check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_access", 32'd1, 32'd0);
                end else begin
                    check("mem_addr", mem_addr, exp_q[0].waddr);
                    if (mem_write) check("mem_wdata", mem_wdata, exp_q[0].wword);
                end
                if (mem_read)  rd_cnt++;
                if (mem_write) wr_cnt++;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("num_reads", 32'(rd_cnt), 32'(e.nrd));
                    check("num_writes", 32'(wr_cnt), 32'(e.nwr));
                    if (e.lat > 0) check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
        check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        check({tag, "_mem_read"},   {31'd0, mem_read},   32'd0);
        check({tag, "_mem_write"},  {31'd0, mem_write},  32'd0);
        check({tag, "_mem_addr"},   mem_addr,            32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        logic [1:0] sz;
        logic [31:0] ad;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Word store then load
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0);

        // Byte RMW and extension
        issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);

        // Error cases
        issue(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h1FFF, 32'h55, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h1FFF, 32'h0, 1'b0);

        // Handshake: request held with changing fields during a sub-word store
        issue(1'b1, 2'b01, 1'b0, 32'h206, 32'h0000CAFE, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);

        // Reset in the RMW read cycle abandons the write
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hA5A5A5A5, 1'b0);
        mon_off = 1'b1;
        wr_before = wr_total;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h301; req_wdata = 32'h3C; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_read_cycle", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_write", 32'(wr_total - wr_before), 32'd0);
        mon_off = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0);

        // Randomized traffic over a small window plus occasional out-of-range
        for (int n = 0; n < 200; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) ad = 32'(MEM_BYTES) + 32'($urandom_range(0, 4096));
            if ($urandom_range(0, 3) == 0) ad = ad & ~(32'(1 << sz) - 32'd1);
            issue(1'($urandom), sz, 1'($urandom), ad, $urandom,
                  ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
